// File: rtl/demux_18_seq_if.sv
// Bundle for the serial-in / parallel-out demux: serial input side plus lane,
// slot and status outputs. "slave" is the demux, "master" is whoever feeds it.
interface demux_18_seq_if;
  logic din;
  logic din_valid;
  logic sof;
  logic y0, y1, y2, y3, y4, y5, y6, y7;
  logic s2, s1, s0;
  logic frame_valid;
  logic frame_err;
  logic busy;
  logic dbg_state;

  // Handshake: din/sof are consumed on every rising clk edge where din_valid=1;
  // there is no back-pressure, the demux always accepts a valid bit.
  modport slave (
    input  din, din_valid, sof,
    output y0, y1, y2, y3, y4, y5, y6, y7,
    output s2, s1, s0, frame_valid, frame_err, busy, dbg_state
  );

  modport master (
    output din, din_valid, sof,
    input  y0, y1, y2, y3, y4, y5, y6, y7,
    input  s2, s1, s0, frame_valid, frame_err, busy, dbg_state
  );
endinterface

// File: rtl/demux_18_seq.sv
// Sequential 1:8 demux / deserializer: collects 8 serial bits into a shadow
// register and publishes them on y0..y7 together when slot 7 arrives.
module demux_18_seq #(
  parameter bit STRICT_SOF = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  demux_18_seq_if.slave   bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] y_q, y_d;
  logic       frame_valid_q, frame_valid_d;
  logic       frame_err_q, frame_err_d;

  logic       start_ok;

  // In IDLE a valid bit opens a frame if it carries sof, or always when
  // STRICT_SOF is cleared.
  assign start_ok = bus.sof || (STRICT_SOF == 1'b0);

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.din_valid && start_ok) begin
          shadow_d[0] = bus.din;
          slot_d      = 3'd1;
          state_d     = COLLECT;
        end
      end

      COLLECT: begin
        if (bus.din_valid) begin
          if (bus.sof) begin
            // Restart: the partial frame is abandoned, y is left untouched.
            frame_err_d = 1'b1;
            shadow_d[0] = bus.din;
            slot_d      = 3'd1;
          end else if (slot_q == 3'd7) begin
            shadow_d[7]   = bus.din;
            y_d           = {bus.din, shadow_q[6:0]};
            frame_valid_d = 1'b1;
            slot_d        = 3'd0;
            state_d       = IDLE;
          end else begin
            shadow_d[slot_q] = bus.din;
            slot_d           = slot_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= 3'd0;
      shadow_q      <= 8'd0;
      y_q           <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.y0          = y_q[0];
  assign bus.y1          = y_q[1];
  assign bus.y2          = y_q[2];
  assign bus.y3          = y_q[3];
  assign bus.y4          = y_q[4];
  assign bus.y5          = y_q[5];
  assign bus.y6          = y_q[6];
  assign bus.y7          = y_q[7];
  assign bus.s2          = slot_q[2];
  assign bus.s1          = slot_q[1];
  assign bus.s0          = slot_q[0];
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = (state_q == COLLECT);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_demux_18_seq.sv
// Directed bench for demux_18_seq: a strict-sof and a non-strict instance
// share clock, reset and serial stimulus.
module tb_demux_18_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  demux_18_seq_if ifs ();
  demux_18_seq_if ifn ();

  demux_18_seq #(.STRICT_SOF(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));
  demux_18_seq #(.STRICT_SOF(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(ifn.slave));

  logic [7:0] ys, yn;
  logic [2:0] ss, sn;
  assign ys = {ifs.y7, ifs.y6, ifs.y5, ifs.y4, ifs.y3, ifs.y2, ifs.y1, ifs.y0};
  assign yn = {ifn.y7, ifn.y6, ifn.y5, ifn.y4, ifn.y3, ifn.y2, ifn.y1, ifn.y0};
  assign ss = {ifs.s2, ifs.s1, ifs.s0};
  assign sn = {ifn.s2, ifn.s1, ifn.s0};

  // Drive one cycle of serial input to both instances; outputs are sampled
  // 1ns after the edge that consumed it.
  task automatic step(input logic v, input logic s, input logic d);
    ifs.din_valid = v; ifs.sof = s; ifs.din = d;
    ifn.din_valid = v; ifn.sof = s; ifn.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ys !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", ys); end
    total++; if (ss !== 3'd0) begin bad++; $display("FAIL reset_s got=%0d exp=0", ss); end
    total++; if (ifs.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", ifs.frame_valid); end
    total++; if (ifs.frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", ifs.frame_err); end
    total++; if (ifs.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ifs.busy); end
    total++; if (ifs.dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", ifs.dbg_state); end
  endtask

  // Bits 1,0,1,1,0,0,1,0 on slots 0..7 -> {y7..y0} = 8'h4D.
  task automatic test_basic_frame();
    logic [7:0] f;
    f = 8'h4D;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, (k == 0), f[k]);
      if (k < 7) begin
        total++; if (ss !== 3'(k + 1)) begin bad++; $display("FAIL basic_s k=%0d got=%0d exp=%0d", k, ss, k + 1); end
        total++; if (ifs.busy !== 1'b1) begin bad++; $display("FAIL basic_busy k=%0d got=%b exp=1", k, ifs.busy); end
        total++; if (ifs.frame_valid !== 1'b0) begin bad++; $display("FAIL basic_fv_early k=%0d got=%b exp=0", k, ifs.frame_valid); end
        total++; if (ys !== 8'h00) begin bad++; $display("FAIL basic_y_early k=%0d got=%h exp=00", k, ys); end
      end
    end
    total++; if (ys !== 8'h4D) begin bad++; $display("FAIL basic_y got=%h exp=4d", ys); end
    total++; if (ifs.frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv got=%b exp=1", ifs.frame_valid); end
    total++; if (ifs.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", ifs.busy); end
    total++; if (ss !== 3'd0) begin bad++; $display("FAIL basic_s_end got=%0d exp=0", ss); end
    step(1'b0, 1'b0, 1'b0);
    total++; if (ifs.frame_valid !== 1'b0) begin bad++; $display("FAIL basic_fv_pulse got=%b exp=0", ifs.frame_valid); end
    total++; if (ys !== 8'h4D) begin bad++; $display("FAIL basic_y_hold got=%h exp=4d", ys); end
  endtask

  task automatic test_gap();
    logic [7:0] f;
    f = 8'h4D;
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, (k == 0), f[k]);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, 1'b1);
      total++; if (ss !== 3'd4) begin bad++; $display("FAIL gap_s g=%0d got=%0d exp=4", g, ss); end
      total++; if (ifs.busy !== 1'b1) begin bad++; $display("FAIL gap_busy g=%0d got=%b exp=1", g, ifs.busy); end
      total++; if (ifs.frame_valid !== 1'b0) begin bad++; $display("FAIL gap_fv g=%0d got=%b exp=0", g, ifs.frame_valid); end
    end
    for (int k = 4; k < 8; k++) step(1'b1, 1'b0, f[k]);
    total++; if (ys !== 8'h4D) begin bad++; $display("FAIL gap_y got=%h exp=4d", ys); end
    total++; if (ifs.frame_valid !== 1'b1) begin bad++; $display("FAIL gap_fv got=%b exp=1", ifs.frame_valid); end
  endtask

  task automatic test_restart();
    // Five bits into a frame, then sof carrying 1 at slot 5.
    for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'b1);
    total++; if (ss !== 3'd5) begin bad++; $display("FAIL rst5_s got=%0d exp=5", ss); end
    step(1'b1, 1'b1, 1'b1);
    total++; if (ifs.frame_err !== 1'b1) begin bad++; $display("FAIL rst5_fe got=%b exp=1", ifs.frame_err); end
    total++; if (ifs.frame_valid !== 1'b0) begin bad++; $display("FAIL rst5_fv got=%b exp=0", ifs.frame_valid); end
    total++; if (ss !== 3'd1) begin bad++; $display("FAIL rst5_s1 got=%0d exp=1", ss); end
    total++; if (ifs.busy !== 1'b1) begin bad++; $display("FAIL rst5_busy got=%b exp=1", ifs.busy); end
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 1) begin
        total++; if (ifs.frame_err !== 1'b0) begin bad++; $display("FAIL rst5_fe_pulse got=%b exp=0", ifs.frame_err); end
      end
      if (k < 7) begin
        total++; if (ys !== 8'h4D) begin bad++; $display("FAIL rst5_y_hold k=%0d got=%h exp=4d", k, ys); end
      end
    end
    total++; if (ys !== 8'h01) begin bad++; $display("FAIL rst5_y got=%h exp=01", ys); end
    total++; if (ifs.frame_valid !== 1'b1) begin bad++; $display("FAIL rst5_fv_end got=%b exp=1", ifs.frame_valid); end
    total++; if (ifs.frame_err !== 1'b0) begin bad++; $display("FAIL rst5_fe_end got=%b exp=0", ifs.frame_err); end

    // sof on the slot-7 edge restarts instead of completing.
    for (int k = 0; k < 7; k++) step(1'b1, (k == 0), 1'b0);
    total++; if (ss !== 3'd7) begin bad++; $display("FAIL rst7_s got=%0d exp=7", ss); end
    step(1'b1, 1'b1, 1'b0);
    total++; if (ifs.frame_err !== 1'b1) begin bad++; $display("FAIL rst7_fe got=%b exp=1", ifs.frame_err); end
    total++; if (ifs.frame_valid !== 1'b0) begin bad++; $display("FAIL rst7_fv got=%b exp=0", ifs.frame_valid); end
    total++; if (ys !== 8'h01) begin bad++; $display("FAIL rst7_y got=%h exp=01", ys); end
    total++; if (ss !== 3'd1) begin bad++; $display("FAIL rst7_s1 got=%0d exp=1", ss); end
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b1);
    total++; if (ys !== 8'hFE) begin bad++; $display("FAIL rst7_y_end got=%h exp=fe", ys); end
    total++; if (ifs.frame_valid !== 1'b1) begin bad++; $display("FAIL rst7_fv_end got=%b exp=1", ifs.frame_valid); end
  endtask

  task automatic test_no_sof();
    logic [7:0] f;
    f = 8'hC3;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, f[k]);
      total++; if (ss !== 3'd0) begin bad++; $display("FAIL strict_s k=%0d got=%0d exp=0", k, ss); end
      total++; if (ifs.busy !== 1'b0) begin bad++; $display("FAIL strict_busy k=%0d got=%b exp=0", k, ifs.busy); end
      total++; if (ifs.frame_valid !== 1'b0) begin bad++; $display("FAIL strict_fv k=%0d got=%b exp=0", k, ifs.frame_valid); end
      if (k < 7) begin
        total++; if (sn !== 3'(k + 1)) begin bad++; $display("FAIL loose_s k=%0d got=%0d exp=%0d", k, sn, k + 1); end
      end
    end
    total++; if (ys !== 8'h00) begin bad++; $display("FAIL strict_y got=%h exp=00", ys); end
    total++; if (yn !== 8'hC3) begin bad++; $display("FAIL loose_y got=%h exp=c3", yn); end
    total++; if (ifn.frame_valid !== 1'b1) begin bad++; $display("FAIL loose_fv got=%b exp=1", ifn.frame_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] f;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, (k == 0), 1'b1);
    total++; if (ys !== 8'hFF) begin bad++; $display("FAIL rmid_y1 got=%h exp=ff", ys); end
    for (int k = 0; k < 4; k++) step(1'b1, (k == 0), 1'b0);
    total++; if (ss !== 3'd4) begin bad++; $display("FAIL rmid_s4 got=%0d exp=4", ss); end
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    total++; if (ys !== 8'h00) begin bad++; $display("FAIL rmid_y0 got=%h exp=00", ys); end
    total++; if (ss !== 3'd0) begin bad++; $display("FAIL rmid_s0 got=%0d exp=0", ss); end
    total++; if (ifs.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", ifs.busy); end
    f = 8'h96;
    for (int k = 0; k < 8; k++) step(1'b1, (k == 0), f[k]);
    total++; if (ys !== 8'h96) begin bad++; $display("FAIL rmid_y2 got=%h exp=96", ys); end
    total++; if (ifs.frame_valid !== 1'b1) begin bad++; $display("FAIL rmid_fv got=%b exp=1", ifs.frame_valid); end
  endtask

  // An 8:1 mux in the bench, its select taken from the demux slot outputs.
  task automatic test_back_to_back();
    logic [7:0] i;
    logic [2:0] sel;
    i = 8'h5A;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      sel = ss;
      step(1'b1, (sel == 3'd0), i[sel]);
      total++; if (ss !== 3'((c + 1) % 8)) begin bad++; $display("FAIL loop_s c=%0d got=%0d exp=%0d", c, ss, (c + 1) % 8); end
      if ((c % 8) == 7) begin
        total++; if (ys !== 8'h5A) begin bad++; $display("FAIL loop_y c=%0d got=%h exp=5a", c, ys); end
        total++; if (ifs.frame_valid !== 1'b1) begin bad++; $display("FAIL loop_fv c=%0d got=%b exp=1", c, ifs.frame_valid); end
      end else begin
        total++; if (ifs.frame_valid !== 1'b0) begin bad++; $display("FAIL loop_fv0 c=%0d got=%b exp=0", c, ifs.frame_valid); end
      end
      total++; if (ifs.frame_err !== 1'b0) begin bad++; $display("FAIL loop_fe c=%0d got=%b exp=0", c, ifs.frame_err); end
    end
  endtask

  initial begin
    ifs.din = 1'b0; ifs.din_valid = 1'b0; ifs.sof = 1'b0;
    ifn.din = 1'b0; ifn.din_valid = 1'b0; ifn.sof = 1'b0;
    test_reset();
    test_basic_frame();
    test_gap();
    test_restart();
    test_no_sof();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
